// File: rtl/uart_bit_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, byte strobe,
// framing-error pulse and a saturating link-loss timer.
module uart_bit_receiver #(
    parameter int CLOCK_FREQ = 8_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int TIMEOUT_MS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       received_bit,
    output logic       link_timeout
);

    localparam int BIT_PERIOD     = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = BIT_PERIOD / 2;
    localparam int TIMEOUT_CYCLES = (CLOCK_FREQ / 1000) * TIMEOUT_MS;
    localparam int BW             = $clog2(BIT_PERIOD + 1);
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] HALF_M1 = BW'(HALF_BIT - 1);
    localparam logic [BW-1:0] BIT_M1  = BW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          s1, s2;
    logic [BW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic          valid_d, ferr_d, rbit_d;
    logic [TW-1:0] to_cnt;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = rx_data;
        rbit_d  = received_bit;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s2) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = s2 ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == BIT_M1) begin
                    timer_d = '0;
                    // Right shift: the first (LSB) bit ends up in shift_q[0].
                    shift_d = {s2, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == BIT_M1) begin
                    timer_d = '0;
                    if (s2) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        rbit_d  = shift_q[0];
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (s2) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizer preloads to idle-high so a reset release never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            state_q      <= IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_error  <= 1'b0;
            received_bit <= 1'b0;
        end else begin
            s1           <= uart_rx;
            s2           <= s1;
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            rx_data      <= data_d;
            rx_valid     <= valid_d;
            frame_error  <= ferr_d;
            received_bit <= rbit_d;
        end
    end

    // Cleared on the same edge that raises rx_valid, so a good byte always wins.
    always_ff @(posedge clk) begin
        if (rst || valid_d) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign link_timeout = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_uart_bit_receiver.sv
// Randomized bench for uart_bit_receiver: frames are driven bit-by-bit and
// outputs are compared every cycle against a frame-level event model.
module tb_uart_bit_receiver;

    localparam int CLOCK_FREQ = 1_152_000;
    localparam int BAUD_RATE  = 115200;
    localparam int TIMEOUT_MS = 1;
    localparam int BP         = CLOCK_FREQ / BAUD_RATE;
    localparam int HB         = BP / 2;
    localparam int TC         = (CLOCK_FREQ / 1000) * TIMEOUT_MS;
    localparam int LAT        = HB + 3 + 9 * BP;
    localparam int W          = 41;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       received_bit;
    logic       link_timeout;

    uart_bit_receiver #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .received_bit(received_bit),
        .link_timeout(link_timeout)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    // scoreboard: each entry is {cycle of pulse, is_error, byte}
    logic [W-1:0] exp_q[$];
    logic [7:0]   data_m = 8'h00;
    logic         bit_m  = 1'b0;
    int           last_evt = 0;
    bit           armed = 1'b0;

    always @(posedge clk) begin
        logic         rst_s;
        logic         exp_v, exp_e, exp_to;
        logic [W-1:0] ev;
        rst_s = rst;
        #2;
        if (rst_s) begin
            armed    = 1'b1;
            data_m   = 8'h00;
            bit_m    = 1'b0;
            last_evt = cyc;
            while (exp_q.size() > 0 && int'(exp_q[$][40:9]) >= cyc) void'(exp_q.pop_back());
        end
        exp_v = 1'b0;
        exp_e = 1'b0;
        while (exp_q.size() > 0 && int'(exp_q[0][40:9]) < cyc) begin
            ev = exp_q.pop_front();
            check("missed_event", 32'(ev[40:9]), 32'(cyc));
        end
        if (exp_q.size() > 0 && int'(exp_q[0][40:9]) == cyc) begin
            ev = exp_q.pop_front();
            if (ev[8]) begin
                exp_e = 1'b1;
            end else begin
                exp_v    = 1'b1;
                data_m   = ev[7:0];
                bit_m    = ev[0];
                last_evt = cyc;
            end
        end
        exp_to = ((cyc - last_evt) >= TC - 1);
        if (armed) begin
            check("rx_valid", 32'(rx_valid), 32'(exp_v));
            check("frame_error", 32'(frame_error), 32'(exp_e));
            check("rx_data", 32'(rx_data), 32'(data_m));
            check("received_bit", 32'(received_bit), 32'(bit_m));
            check("link_timeout", 32'(link_timeout), 32'(exp_to));
        end
    end

    // driver tasks (entered and left on a falling edge)
    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_at);
        logic [9:0] bits;
        int         t0;
        bits = {stop_bit, b, 1'b0};
        t0   = cyc;
        exp_q.push_back({32'(t0 + LAT), ~stop_bit, b});
        for (int i = 0; i < 10 * BP; i++) begin
            uart_rx = bits[i / BP];
            rst     = (i == rst_at);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic send_break(input int n);
        exp_q.push_back({32'(cyc + LAT), 1'b1, 8'h00});
        uart_rx = 1'b0;
        repeat (n) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic glitch(input int n);
        uart_rx = 1'b0;
        repeat (n) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;
        uart_rx = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(10);

        send_frame(8'h01, 1'b1, -1);
        idle(20);

        send_frame(8'h01, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'h01, 1'b1, -1);
        idle(20);

        glitch(3);
        idle(20);
        send_frame(8'h55, 1'b1, -1);
        idle(10);

        send_break(300);
        idle(20);
        send_frame(8'($urandom_range(0, 255)), 1'b1, -1);

        idle(TC + 50);
        send_frame(8'h01, 1'b1, -1);
        idle(10);

        send_frame(8'hF0 | 8'($urandom_range(0, 15)), 1'b1, 50);
        idle(150);
        send_frame(8'h01, 1'b1, -1);
        idle(10);

        for (int k = 0; k < 20; k++) begin
            b  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 4) != 0);
            send_frame(b, sb, -1);
            if (!sb) idle($urandom_range(3, 15));
            else     idle($urandom_range(0, 12));
        end

        idle(LAT + 20);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bit_receiver.md
Name: uart_bit_receiver

Overview:
- 8N1 UART receiver for the board's serial link, at 115200 baud by default.
- Decodes the periodic 1/0 frames from the transmitter side and reconstructs the toggling bit on `received_bit` (LED drive).
- Presents the full byte with a one-cycle valid strobe.
- Flags framing errors, and flags link loss when no valid frame arrives within a timeout.

Parameters:
- CLOCK_FREQ, 8_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate. BIT_PERIOD = CLOCK_FREQ/BAUD_RATE, integer division (69 at defaults). HALF_BIT = BIT_PERIOD/2 (34).
- TIMEOUT_MS, 500: link-timeout window in ms. TIMEOUT_CYCLES = (CLOCK_FREQ/1000)*TIMEOUT_MS.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- uart_rx, input, 1: asynchronous serial line; idles high.
- rx_data, output, 8: last correctly framed byte, LSB received first.
- rx_valid, output, 1: one-cycle pulse; rx_data updated in the same cycle.
- frame_error, output, 1: one-cycle pulse when the stop bit is sampled low.
- received_bit, output, 1: bit 0 of the last valid byte; held until the next valid byte.
- link_timeout, output, 1: high while no valid frame has arrived for TIMEOUT_CYCLES cycles.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, frame_error=0, received_bit=0, link_timeout=0.
  - Both synchronizer flops=1, state=IDLE, all counters=0.
- Reset mid-frame: abandons the frame with no strobe. The synchronizer preload of 1 prevents a false start on release.
- Input synchronizer: 2 flops (s1, s2). All decoding uses s2 only.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - s2==0 -> START, bit_timer=0.
- START:
  - bit_timer increments each cycle.
  - At bit_timer==HALF_BIT-1: if s2==0 -> DATA, bit_timer=0, bit_idx=0; else -> IDLE (glitch rejected, no output).
- DATA:
  - bit_timer counts 0..BIT_PERIOD-1 and wraps to 0.
  - At wrap: shift s2 into shift_reg[7], shifting right, so LSB-first bytes land correctly. Then bit_idx++.
  - Leaving sample at bit_idx==7 -> STOP.
- STOP:
  - At bit_timer==BIT_PERIOD-1, sample s2.
  - If 1: rx_data<=shift_reg, received_bit<=shift_reg[0], rx_valid<=1 for one cycle -> IDLE.
  - If 0: frame_error<=1 for one cycle, rx_data and received_bit unchanged -> WAIT_IDLE.
- WAIT_IDLE:
  - Stays until s2==1, then -> IDLE.
  - Prevents a break or stuck-low line from re-triggering a start.
- Latency:
  - Let cycle 0 be the first rising edge at which uart_rx is sampled low into s1.
  - rx_valid (or frame_error) is high during cycle HALF_BIT+3+9*BIT_PERIOD, i.e. 658 at defaults.
  - Data bit k is sampled at cycle HALF_BIT+2+(k+1)*BIT_PERIOD.
- Back-to-back frames: the stop sample occurs mid stop bit and the FSM returns to IDLE on the next cycle. A start edge in the second half of the stop bit is therefore caught with no lost frame.
- Timeout counter (saturating, width ≥ clog2(TIMEOUT_CYCLES)):
  - Cleared to 0 on every rx_valid; otherwise increments.
  - At TIMEOUT_CYCLES-1 it holds, and link_timeout=1.
  - link_timeout clears in the same cycle rx_valid pulses.
  - frame_error does not clear the counter.
- Simultaneous rx_valid and timeout saturation in the same cycle: rx_valid wins, so counter=0 and link_timeout=0.
- rx_valid and frame_error are never both high in the same cycle.

Test Plan:
- Bench parameters: CLOCK_FREQ=1_152_000, BAUD_RATE=115200 (BIT_PERIOD=10, HALF_BIT=5), TIMEOUT_MS=1 (TIMEOUT_CYCLES=1152).
- Valid frame 0x01 (start 0, data 1000_0000 LSB-first, stop 1), first low at cycle 0:
  - rx_valid is a single pulse at cycle 98.
  - rx_data=0x01, received_bit=1, frame_error=0 throughout.
- Alternating frames 0x01, 0x00, 0x01 back-to-back with no idle gap:
  - Three rx_valid pulses, exactly 100 cycles apart.
  - received_bit goes 1 -> 0 -> 1.
- Glitch: uart_rx low for 3 cycles, then high:
  - No rx_valid, no frame_error, FSM back in IDLE.
  - A following valid 0x55 is received correctly.
- Break: uart_rx held low 300 cycles, then high:
  - Exactly one frame_error pulse, at cycle 98.
  - rx_data and received_bit keep their prior values.
  - No further pulses; the next valid frame decodes normally.
- Timeout: after one valid frame, idle the line for 1152 cycles:
  - link_timeout rises and stays high.
  - The next valid frame clears it in the rx_valid cycle.
- Reset mid-frame: assert rst for 1 cycle at cycle 50 of a frame:
  - All outputs return to 0 and no strobe occurs for that frame.
  - A subsequent 0x01 frame yields rx_valid and received_bit=1.
